wd_kick_master: RTL and testbench

//  Bus-side initiator for the watchdog: generates 68k-style byte write cycles to $300001 (the watchdog kick).

---
 rtl/wd_kick_master.sv | 187 ++++++++++++++++++
 tb/tb_wd_kick_master.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wd_kick_master.sv
// Secondary bus master that issues 68k-style byte write cycles to $300001 to kick the watchdog.
// Kicks come from a periodic timer (AUTO_EN) or from KICK_REQ, arbitrated via BUS_REQ/BUS_GRANT.
module wd_kick_master #(
  parameter logic [23:0] PERIOD     = 24'd1200000,
  parameter logic [3:0]  STROBE_LEN = 4'd4
) (
  input  logic       CLK_24M,
  input  logic       RESET,
  input  logic       AUTO_EN,
  input  logic       KICK_REQ,
  output logic       KICK_ACK,
  output logic       BUS_REQ,
  input  logic       BUS_GRANT,
  output logic       nLDS,
  output logic       RW,
  output logic       A23I,
  output logic       A22I,
  output logic [4:0] M68K_ADDR_U,
  output logic       BUSY,
  output logic [7:0] KICK_CNT
);

  localparam logic [4:0] KickAddrU = 5'b11000;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StSetup,
    StStrobe,
    StHold
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  strobe_cnt_q, strobe_cnt_d;
  logic [23:0] timer_q, timer_d;
  logic        pending_q, pending_d;
  logic [7:0]  kick_cnt_q, kick_cnt_d;

  logic        nlds_q, nlds_d;
  logic        rw_q, rw_d;
  logic [4:0]  addr_u_q, addr_u_d;
  logic        bus_req_q, bus_req_d;
  logic        busy_q, busy_d;
  logic        ack_q, ack_d;

  logic        kick_done;
  logic        timer_expire;

  // The HOLD cycle is the cycle in which KICK_ACK is high.
  assign kick_done    = (state_q == StHold);
  assign timer_expire = AUTO_EN && (timer_q == PERIOD - 24'd1);

  always_comb begin
    state_d      = state_q;
    strobe_cnt_d = strobe_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pending_q) state_d = StReq;
      end
      StReq: begin
        if (BUS_GRANT) state_d = StSetup;
      end
      StSetup: begin
        if (!BUS_GRANT) begin
          state_d = StIdle;
        end else begin
          state_d      = StStrobe;
          strobe_cnt_d = 4'd0;
        end
      end
      StStrobe: begin
        if (!BUS_GRANT) begin
          state_d = StIdle;
        end else if (strobe_cnt_q == STROBE_LEN - 4'd1) begin
          state_d = StHold;
        end else begin
          strobe_cnt_d = strobe_cnt_q + 4'd1;
        end
      end
      StHold: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Completion restarts the auto period; an expiry coinciding with it is absorbed.
  always_comb begin
    timer_d    = timer_q;
    pending_d  = pending_q;
    kick_cnt_d = kick_cnt_q;
    if (kick_done || !AUTO_EN) begin
      timer_d = 24'd0;
    end else if (timer_expire) begin
      timer_d = 24'd0;
    end else begin
      timer_d = timer_q + 24'd1;
    end
    if (kick_done) begin
      pending_d  = 1'b0;
      kick_cnt_d = kick_cnt_q + 8'd1;
    end else if (timer_expire || (state_q == StIdle && KICK_REQ)) begin
      pending_d = 1'b1;
    end
  end

  // Bus outputs are registered from the next state so they change cleanly on the edge.
  always_comb begin
    nlds_d    = 1'b1;
    rw_d      = 1'b1;
    addr_u_d  = 5'b00000;
    bus_req_d = 1'b0;
    busy_d    = 1'b0;
    ack_d     = 1'b0;
    unique case (state_d)
      StIdle: begin
      end
      StReq: begin
        bus_req_d = 1'b1;
        busy_d    = 1'b1;
      end
      StSetup: begin
        bus_req_d = 1'b1;
        busy_d    = 1'b1;
        rw_d      = 1'b0;
        addr_u_d  = KickAddrU;
      end
      StStrobe: begin
        bus_req_d = 1'b1;
        busy_d    = 1'b1;
        rw_d      = 1'b0;
        addr_u_d  = KickAddrU;
        nlds_d    = 1'b0;
      end
      StHold: begin
        bus_req_d = 1'b1;
        busy_d    = 1'b1;
        rw_d      = 1'b0;
        addr_u_d  = KickAddrU;
        ack_d     = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      state_q      <= StIdle;
      strobe_cnt_q <= 4'd0;
      timer_q      <= 24'd0;
      pending_q    <= 1'b0;
      kick_cnt_q   <= 8'd0;
      nlds_q       <= 1'b1;
      rw_q         <= 1'b1;
      addr_u_q     <= 5'b00000;
      bus_req_q    <= 1'b0;
      busy_q       <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      strobe_cnt_q <= strobe_cnt_d;
      timer_q      <= timer_d;
      pending_q    <= pending_d;
      kick_cnt_q   <= kick_cnt_d;
      nlds_q       <= nlds_d;
      rw_q         <= rw_d;
      addr_u_q     <= addr_u_d;
      bus_req_q    <= bus_req_d;
      busy_q       <= busy_d;
      ack_q        <= ack_d;
    end
  end

  assign nLDS        = nlds_q;
  assign RW          = rw_q;
  assign A23I        = 1'b0;
  assign A22I        = 1'b0;
  assign M68K_ADDR_U = addr_u_q;
  assign BUS_REQ     = bus_req_q;
  assign BUSY        = busy_q;
  assign KICK_ACK    = ack_q;
  assign KICK_CNT    = kick_cnt_q;

endmodule

// File: tb/tb_wd_kick_master.sv
// Directed bench for wd_kick_master: per-cycle vector table plus auto-period and count-wrap runs.
module tb_wd_kick_master;

  localparam int PhI = 0;  // idle
  localparam int PhR = 1;  // bus requested
  localparam int PhS = 2;  // setup
  localparam int PhT = 3;  // strobe
  localparam int PhH = 4;  // hold / ack

  logic       clk;
  logic       rst;
  logic       auto_en;
  logic       kick_req;
  logic       kick_ack;
  logic       bus_req;
  logic       bus_grant;
  logic       nlds;
  logic       rw;
  logic       a23i;
  logic       a22i;
  logic [4:0] addr_u;
  logic       busy;
  logic [7:0] kick_cnt;

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  typedef struct {
    logic       rst;
    logic       auto_en;
    logic       kreq;
    logic       gnt;
    int         phase;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  wd_kick_master #(
    .PERIOD     (24'd16),
    .STROBE_LEN (4'd4)
  ) dut (
    .CLK_24M     (clk),
    .RESET       (rst),
    .AUTO_EN     (auto_en),
    .KICK_REQ    (kick_req),
    .KICK_ACK    (kick_ack),
    .BUS_REQ     (bus_req),
    .BUS_GRANT   (bus_grant),
    .nLDS        (nlds),
    .RW          (rw),
    .A23I        (a23i),
    .A22I        (a22i),
    .M68K_ADDR_U (addr_u),
    .BUSY        (busy),
    .KICK_CNT    (kick_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {nLDS, RW, BUS_REQ, BUSY, KICK_ACK, A23I, A22I, ADDR_U[4:0], KICK_CNT[7:0]}
  function automatic logic [19:0] exp_vec(input int phase, input logic [7:0] cnt);
    case (phase)
      PhR:     return {5'b11110, 2'b00, 5'b00000, cnt};
      PhS:     return {5'b10110, 2'b00, 5'b11000, cnt};
      PhT:     return {5'b00110, 2'b00, 5'b11000, cnt};
      PhH:     return {5'b10111, 2'b00, 5'b11000, cnt};
      default: return {5'b11000, 2'b00, 5'b00000, cnt};
    endcase
  endfunction

  task automatic add(input logic r, input logic a, input logic k, input logic g,
                     input int ph, input logic [7:0] c, input int reps);
    vec_t v;
    v.rst = r; v.auto_en = a; v.kreq = k; v.gnt = g; v.phase = ph; v.cnt = c;
    for (int i = 0; i < reps; i++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // nLDS low must always come with a fully set-up write cycle on an owned bus.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (nlds === 1'b0 && (rw !== 1'b0 || addr_u !== 5'b11000 || bus_req !== 1'b1 ||
                            a23i !== 1'b0 || a22i !== 1'b0)) begin
        errors++;
        $display("FAIL strobe_qual: rw=%b addr_u=%b bus_req=%b", rw, addr_u, bus_req);
      end
    end
  end

  task automatic do_kick(input int n);
    bit seen;
    @(negedge clk) kick_req = 1'b1;
    @(negedge clk) kick_req = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (kick_ack === 1'b1) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL kick_timeout: kick %0d got no ack, expected ack within 20 cycles", n);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [19:0] act;
    int acks, first_ack, last_ack, low_cycles;

    rst = 1'b1; auto_en = 1'b0; kick_req = 1'b0; bus_grant = 1'b1;

    // reset, single manual kick
    add(1, 0, 0, 1, PhI, 8'd0, 2);
    add(0, 0, 1, 1, PhI, 8'd0, 1);
    add(0, 0, 0, 1, PhR, 8'd0, 1);
    add(0, 0, 0, 1, PhS, 8'd0, 1);
    add(0, 0, 0, 1, PhT, 8'd0, 4);
    add(0, 0, 0, 1, PhH, 8'd0, 1);
    add(0, 0, 0, 1, PhI, 8'd1, 2);
    // no grant: request waits, then regrant
    add(0, 0, 1, 0, PhI, 8'd1, 1);
    add(0, 0, 0, 0, PhR, 8'd1, 4);
    add(0, 0, 0, 1, PhS, 8'd1, 1);
    add(0, 0, 0, 1, PhT, 8'd1, 4);
    add(0, 0, 0, 1, PhH, 8'd1, 1);
    add(0, 0, 0, 1, PhI, 8'd2, 1);
    // grant lost in 2nd strobe cycle, pending retained
    add(0, 0, 1, 1, PhI, 8'd2, 1);
    add(0, 0, 0, 1, PhR, 8'd2, 1);
    add(0, 0, 0, 1, PhS, 8'd2, 1);
    add(0, 0, 0, 1, PhT, 8'd2, 2);
    add(0, 0, 0, 0, PhI, 8'd2, 1);
    add(0, 0, 0, 1, PhR, 8'd2, 1);
    add(0, 0, 0, 1, PhS, 8'd2, 1);
    add(0, 0, 0, 1, PhT, 8'd2, 4);
    add(0, 0, 0, 1, PhH, 8'd2, 1);
    add(0, 0, 0, 1, PhI, 8'd3, 1);
    // reset during strobe aborts
    add(0, 0, 1, 1, PhI, 8'd3, 1);
    add(0, 0, 0, 1, PhR, 8'd3, 1);
    add(0, 0, 0, 1, PhS, 8'd3, 1);
    add(0, 0, 0, 1, PhT, 8'd3, 1);
    add(1, 0, 0, 1, PhI, 8'd0, 1);
    add(0, 0, 0, 1, PhI, 8'd0, 2);
    // KICK_REQ held high: back-to-back kicks
    add(0, 0, 1, 1, PhI, 8'd0, 1);
    add(0, 0, 1, 1, PhR, 8'd0, 1);
    add(0, 0, 1, 1, PhS, 8'd0, 1);
    add(0, 0, 1, 1, PhT, 8'd0, 4);
    add(0, 0, 1, 1, PhH, 8'd0, 1);
    add(0, 0, 1, 1, PhI, 8'd1, 2);
    add(0, 0, 1, 1, PhR, 8'd1, 1);
    add(0, 0, 0, 1, PhS, 8'd1, 1);
    add(0, 0, 0, 1, PhT, 8'd1, 4);
    add(0, 0, 0, 1, PhH, 8'd1, 1);
    add(0, 0, 0, 1, PhI, 8'd2, 2);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; auto_en = vecs[i].auto_en;
      kick_req = vecs[i].kreq; bus_grant = vecs[i].gnt;
      @(posedge clk); #1;
      mon_en = 1;
      act = {nlds, rw, bus_req, busy, kick_ack, a23i, a22i, addr_u, kick_cnt};
      check($sformatf("vec%0d", i), {12'd0, act}, {12'd0, exp_vec(vecs[i].phase, vecs[i].cnt)});
    end

    // Auto mode, PERIOD=16: kicks ack at cycles 23, 47, 71, 95 after reset release.
    @(negedge clk) rst = 1'b1; auto_en = 1'b1; kick_req = 1'b0; bus_grant = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    acks = 0; first_ack = 0; last_ack = 0; low_cycles = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (kick_ack === 1'b1) begin
        acks++;
        if (first_ack == 0) first_ack = k;
        last_ack = k;
      end
      if (nlds === 1'b0) low_cycles++;
    end
    check("auto_acks", acks, 4);
    check("auto_first_ack", first_ack, 23);
    check("auto_last_ack", last_ack, 95);
    check("auto_strobe_cycles", low_cycles, 16);
    check("auto_kick_cnt", {24'd0, kick_cnt}, 32'd4);

    // Count wraps after 256 kicks
    @(negedge clk) rst = 1'b1; auto_en = 1'b0;
    @(posedge clk); #1;
    check("wrap_reset_cnt", {24'd0, kick_cnt}, 32'd0);
    @(negedge clk) rst = 1'b0;
    for (int n = 1; n <= 256; n++) begin
      do_kick(n);
      if (n == 1)   check("wrap_cnt_1", {24'd0, kick_cnt}, 32'd1);
      if (n == 255) check("wrap_cnt_255", {24'd0, kick_cnt}, 32'd255);
      if (n == 256) check("wrap_cnt_256", {24'd0, kick_cnt}, 32'd0);
    end
    check("wrap_idle_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
